serial_word_tx: RTL and testbench
=================================

// Module: serial_word_tx
// PURPOSE
// - Upstream feeder for the serial pattern detector: accepts parallel words over a
//   valid/ready handshake, buffers them in a small FIFO and shifts them out one bit
//   per enabled clock on serial_out.
// - serial_out drives the detector's serial_in directly; bit_valid marks real data
//   versus idle fill.
// PARAMETERS
// - DATA_W      8   word width in bits (>=2)
// - FIFO_DEPTH  4   input FIFO entries (power of 2, >=2)
// - IDLE_BIT    0   level driven on serial_out when no data is being shifted
// PORTS
// - clk         in   1                     clock, all state on rising edge
// - reset_n     in   1                     reset, asynchronous, active-low
// - in_valid    in   1                     in_data valid
// - in_ready    out  1                     FIFO can accept; push = in_valid & in_ready
// - in_data     in   DATA_W                word to transmit
// - enable      in   1                     shift strobe; low = freeze shifter
// - serial_out  out  1                     serial bit stream, registered
// - bit_valid   out  1                     serial_out carries a data (or parity) bit
// - word_done   out  1                     1-cycle pulse while last bit of a word is driven
// - fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently in FIFO
// BEHAVIOUR
// - Reset: FIFO empty, fifo_level=0, in_ready=1, serial_out=IDLE_BIT,
//   bit_valid=0, word_done=0, FSM=IDLE, bit counter=0.
// - FIFO: in_ready = (fifo_level != FIFO_DEPTH). A push while full is impossible
//   (in_ready=0), even in a cycle that also pops. Push and pop in the same cycle
//   leave fifo_level unchanged. Pointers wrap modulo FIFO_DEPTH.
// - FSM states: IDLE, SHIFT (PARITY only with the option).
//   IDLE: serial_out=IDLE_BIT, bit_valid=0. On an edge with enable=1 and FIFO
//   non-empty: pop the head word into the shift register, serial_out<=word[DATA_W-1],
//   bit_valid<=1, cnt<=DATA_W-1, go to SHIFT.
//   SHIFT, enable=1: if cnt!=0, drive the next lower bit and decrement cnt.
//   On the edge after the last bit (cnt==0): pop the next word back-to-back if the
//   FIFO is non-empty (no gap cycle), otherwise go to IDLE.
// - Bit order: MSB first. Exactly one bit per enabled cycle.
// - enable=0: FSM, cnt, shift register and serial_out/bit_valid hold; FIFO still accepts
//   pushes; no pop. word_done is only asserted in a cycle with enable=1.
// - Latency: word pushed at edge N into an empty FIFO while IDLE with enable held at 1:
//   MSB on serial_out after edge N+1; LSB after edge N+DATA_W.
// - word_done=1 in the cycle the word's final bit is on serial_out and enable=1
//   (the LSB, or the parity bit with the option).
// - Reset mid-word: the partial word and all FIFO contents are discarded; outputs
//   return to reset values asynchronously.
// CONFIGURATION
// - SER_TX_PARITY_EN defined: after the LSB, FSM enters PARITY for one enabled cycle.
//   It drives ^word (even parity), bit_valid=1, then pops/IDLE as for end of SHIFT.
//   Word period = DATA_W+1 enabled cycles.
// - Not defined: no PARITY state; word period = DATA_W enabled cycles.
// TESTING
// - Reset then idle: hold in_valid=0 for 10 cycles -> serial_out=IDLE_BIT, bit_valid=0,
//   in_ready=1, fifo_level=0.
// - Single word 8'hA5, enable=1 -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles
//   starting 1 cycle after push; word_done with the final 1; then IDLE.
// - Back-to-back 8'hFF,8'h00,8'h3C -> 24 contiguous bit_valid cycles with no gap,
//   3 word_done pulses.
// - Fill with enable=0: push 5 words -> in_ready=0 after the 4th, fifo_level=4,
//   5th held; raise enable -> 5th accepted after the first pop; all 5 words emitted in order.
// - Enable stall: drop enable for 3 cycles after bit 3 of 8'hC3 -> serial_out holds bit 3;
//   stream resumes intact.
// - Reset mid-word: assert reset_n=0 after bit 4 of 8'h96 with 2 words queued ->
//   outputs reset at once; nothing is emitted after release.
//   Parity build: 8'h07 -> parity bit 1 follows the LSB.

Source files
------------

// File: rtl/serial_word_tx.sv
// serial_word_tx: buffers valid/ready words in a small FIFO and shifts them out MSB first.
// Define SER_TX_PARITY_EN to append one even-parity bit after each word's LSB.
module serial_word_tx #(
  parameter int   DATA_W     = 8,
  parameter int   FIFO_DEPTH = 4,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             enable,
  output logic                             serial_out,
  output logic                             bit_valid,
  output logic                             word_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(DATA_W);

`ifdef SER_TX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic {S_IDLE, S_SHIFT} state_t;
`endif

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] head_word;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              sout_q, sout_d;
  logic              bv_q, bv_d;
  logic              word_end;
`ifdef SER_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign fifo_empty = (level_q == '0);
  assign in_ready   = (level_q != LVL_W'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  assign head_word  = mem_q[rd_ptr_q];

  // word_end marks the enabled cycle in which the final bit of a word is on serial_out.
`ifdef SER_TX_PARITY_EN
  assign word_end = enable && (state_q == S_PARITY);
`else
  assign word_end = enable && (state_q == S_SHIFT) && (cnt_q == '0);
`endif
  assign pop = enable && !fifo_empty && ((state_q == S_IDLE) || word_end);

  assign serial_out = sout_q;
  assign bit_valid  = bv_q;
  assign word_done  = word_end;
  assign fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      sout_q  <= IDLE_BIT;
      bv_q    <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      sout_q  <= sout_d;
      bv_q    <= bv_d;
`ifdef SER_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    sout_d  = sout_q;
    bv_d    = bv_q;
`ifdef SER_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (pop) begin
      // shift_q always holds the bits still to come, left-aligned.
      state_d = S_SHIFT;
      shift_d = head_word << 1;
      sout_d  = head_word[DATA_W-1];
      bv_d    = 1'b1;
      cnt_d   = CNT_W'(DATA_W - 1);
`ifdef SER_TX_PARITY_EN
      par_d   = ^head_word;
`endif
    end else if (word_end) begin
      state_d = S_IDLE;
      sout_d  = IDLE_BIT;
      bv_d    = 1'b0;
    end else if (enable && (state_q == S_SHIFT)) begin
      if (cnt_q != '0) begin
        sout_d  = shift_q[DATA_W-1];
        shift_d = shift_q << 1;
        cnt_d   = cnt_q - CNT_W'(1);
      end
`ifdef SER_TX_PARITY_EN
      else begin
        state_d = S_PARITY;
        sout_d  = par_q;
      end
`endif
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed table vectors plus hand-written sequences for serial_word_tx.
module tb_serial_word_tx;
`ifdef SER_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int W = 8 + PAR;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       enable = 1'b0;
  logic       serial_out;
  logic       bit_valid;
  logic       word_done;
  logic [2:0] fifo_level;

  serial_word_tx #(.DATA_W(8), .FIFO_DEPTH(4), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .enable(enable), .serial_out(serial_out),
    .bit_valid(bit_valid), .word_done(word_done), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       e;
    logic [6:0] exp; // {ready, sout, bv, wd, level}
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;
  bit   cap_q[$];
  bit   exp_q[$];
  int   wd_cnt, wd_bad, bv_rises, pushes;
  logic bv_prev, last_ready, last_wd_bit;
  logic [2:0] last_level;

  function automatic void add(input logic v, input logic [7:0] d, input logic e,
                              input logic r, input logic s, input logic b,
                              input logic w, input logic [2:0] l);
    tbl.push_back('{v: v, d: d, e: e, exp: {r, s, b, w, l}});
  endfunction

  function automatic void expect_word(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
    if (PAR != 0) exp_q.push_back(^w);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic clr();
    cap_q.delete(); exp_q.delete();
    wd_cnt = 0; wd_bad = 0; bv_rises = 0; pushes = 0; bv_prev = 1'b0;
  endtask

  // Drive one cycle's inputs, sample just after, then advance to the next edge.
  task automatic step(input logic v, input logic [7:0] d, input logic e);
    in_valid = v; in_data = d; enable = e;
    #1;
    last_ready = in_ready;
    last_level = fifo_level;
    if (v && in_ready) pushes++;
    if (bit_valid && e) cap_q.push_back(serial_out);
    if (word_done) begin
      wd_cnt++;
      last_wd_bit = serial_out;
      if (!e) wd_bad++;
    end
    if (bit_valid && !bv_prev) bv_rises++;
    bv_prev = bit_valid;
    @(posedge clk); #1;
  endtask

  task automatic chk_stream(input string name);
    int mism;
    mism = 0;
    chk({name, "_len"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (cap_q[i] != exp_q[i]) mism++;
    chk({name, "_bits"}, mism, 0);
    $display("stream %s: %0d bits captured, %0d expected", name, cap_q.size(), exp_q.size());
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] fw [5];
    clr();
    last_ready = 1'b0; last_level = '0; last_wd_bit = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {in_ready, serial_out, bit_valid, word_done, fifo_level}, 7'b1000000);
    reset_n = 1'b1;

    // Idle hold, then single word A5.
    for (int i = 0; i < 10; i++) add(0, 8'h00, 1, 1, 0, 0, 0, 3'd0);
    add(1, 8'hA5, 1, 1, 0, 0, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 3'd1);
    add(0, 8'h00, 1, 1, 1, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 1, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 1, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 1, 0, 3'd0);
`ifdef SER_TX_PARITY_EN
    add(0, 8'h00, 1, 1, 1, 1, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 1, 1, 3'd0);
`else
    add(0, 8'h00, 1, 1, 1, 1, 1, 3'd0);
`endif
    add(0, 8'h00, 1, 1, 0, 0, 0, 3'd0);
    add(0, 8'h00, 1, 1, 0, 0, 0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; enable = tbl[i].e;
      #1;
      $display("vec %0d v=%0b d=%h e=%0b out=%b", i, tbl[i].v, tbl[i].d, tbl[i].e,
               {in_ready, serial_out, bit_valid, word_done, fifo_level});
      chk($sformatf("vec%0d", i), {in_ready, serial_out, bit_valid, word_done, fifo_level},
          tbl[i].exp);
      @(posedge clk); #1;
    end

    // Back-to-back words: one contiguous bit_valid run.
    clr();
    step(1, 8'hFF, 1); step(1, 8'h00, 1); step(1, 8'h3C, 1);
    for (int i = 0; i < 3 * W + 4; i++) step(0, 8'h00, 1);
    expect_word(8'hFF); expect_word(8'h00); expect_word(8'h3C);
    chk_stream("b2b");
    chk("b2b_word_done", wd_cnt, 3);
    chk("b2b_contiguous", bv_rises, 1);

    // Fill with enable low, fifth word held until the first pop.
    clr();
    fw[0] = 8'h81; fw[1] = 8'h42; fw[2] = 8'h24; fw[3] = 8'h18; fw[4] = 8'hE7;
    for (int i = 0; i < 4; i++) begin
      step(1, fw[i], 0);
      chk($sformatf("fill_ready%0d", i), last_ready, 1);
      chk($sformatf("fill_level%0d", i), last_level, i);
    end
    for (int i = 0; i < 2; i++) begin
      step(1, fw[4], 0);
      chk("full_ready", last_ready, 0);
      chk("full_level", last_level, 4);
    end
    chk("full_no_bits", bv_rises, 0);
    step(1, fw[4], 1);
    chk("full_pop_ready", last_ready, 0);
    for (int i = 0; i < 5 && pushes < 5; i++) step(1, fw[4], 1);
    chk("fill_pushes", pushes, 5);
    for (int i = 0; i < 5 * W + 4; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 5; i++) expect_word(fw[i]);
    chk_stream("fill");
    chk("fill_word_done", wd_cnt, 5);

    // Enable stall while bit 3 of C3 is on the line.
    clr();
    step(1, 8'hC3, 1); step(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; enable = 1'b0;
      #1;
      chk($sformatf("stall%0d", i), {serial_out, bit_valid, word_done}, 3'b010);
      @(posedge clk); #1;
    end
    for (int i = 0; i < W + 2; i++) step(0, 8'h00, 1);
    expect_word(8'hC3);
    chk_stream("stall");
    chk("stall_word_done", wd_cnt, 1);
    chk("stall_wd_gated", wd_bad, 0);

    // Word 07: LSB (and parity bit, if built in) ends the word.
    clr();
    step(1, 8'h07, 1);
    for (int i = 0; i < W + 3; i++) step(0, 8'h00, 1);
    expect_word(8'h07);
    chk_stream("w07");
    chk("w07_word_done", wd_cnt, 1);
    chk("w07_final_bit", last_wd_bit, 1);

    // Reset mid-word with two words queued.
    clr();
    step(1, 8'h96, 1); step(1, 8'h11, 1); step(1, 8'h22, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
    #1;
    chk("pre_reset", {bit_valid, fifo_level}, 4'b1010);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {in_ready, serial_out, bit_valid, word_done, fifo_level}, 7'b1000000);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    clr();
    for (int i = 0; i < 20; i++) step(0, 8'h00, 1);
    chk("post_reset_bits", cap_q.size(), 0);
    chk("post_reset_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
